// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler: geometry, FSM states, expected frame length.
// No logic here; latency and backpressure are properties of the modules that import it.
// Consumers: fft_mem_sched (FSM, counters) and fft_mem_mux (SRAM steering).
package fft_pkg;
    localparam int FFT_AW           = 10;
    localparam int FFT_DW           = 32;
    localparam int FFT_N            = 1024;
    localparam int FFT_FRAME_CYCLES = 35840;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        RUN,
        DONE
    } fft_state_t;
endpackage

// File: rtl/fft_mem_mux.sv
// Combinational host/engine steering onto the single-port sample SRAM, with optional bit-reversed host reads.
// Latency: zero cycles, pure combinational path.
// Backpressure: none here; the owner is chosen upstream, and a non-owner request is simply not driven.
module fft_mem_mux
    import fft_pkg::*;
#(
    parameter int AW = FFT_AW,
    parameter int DW = FFT_DW
) (
    input  logic          host_sel,
    input  logic          rev_en,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          fft_cs,
    input  logic          fft_we,
    input  logic [AW-1:0] fft_addr,
    input  logic [DW-1:0] fft_wdata,
    output logic          m_cs,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata
);
    logic [AW-1:0] h_addr_map;

    // Without the bit-reverse build option the map is the identity, so the select below is harmless.
    always_comb begin
        h_addr_map = h_addr;
`ifdef FFT_BITREV_READ_EN
        for (int i = 0; i < AW; i++) begin
            h_addr_map[i] = h_addr[AW-1-i];
        end
`endif
    end

    always_comb begin
        m_cs    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (host_sel) begin
            if (h_req) begin
                m_cs    = 1'b1;
                m_we    = h_we;
                m_addr  = (rev_en && !h_we) ? h_addr_map : h_addr;
                m_wdata = h_wdata;
            end
        end else if (fft_cs) begin
            m_cs    = 1'b1;
            m_we    = fft_we;
            m_addr  = fft_addr;
            m_wdata = fft_wdata;
        end
    end
endmodule

// File: rtl/fft_mem_sched.sv
// Frame scheduler and SRAM arbiter for the in-place 1024-point FFT; FFT_BITREV_READ_EN enables bit-reversed host reads.
// Latency: host ack combinational in IDLE, read data one cycle after ack; fft_start one cycle after go.
// Backpressure: host request is held off (h_ack=0) outside IDLE; go outside IDLE is dropped.
module fft_mem_sched
    import fft_pkg::*;
#(
    parameter int AW     = FFT_AW,
    parameter int DW     = FFT_DW,
    parameter int WD_LIM = 4
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   run_cycles,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          fft_start,
    input  logic          fft_ready,
    input  logic          fft_cs,
    input  logic          fft_we,
    input  logic [AW-1:0] fft_addr,
    input  logic [DW-1:0] fft_wdata,
    output logic [DW-1:0] fft_rdata,
    output logic          m_cs,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    localparam int WDW = (WD_LIM > 1) ? $clog2(WD_LIM) : 1;

    fft_state_t    state, state_nxt;
    logic [WDW-1:0] wd_cnt;
    logic          wd_expire;
    logic          go_acc;
    logic          frame_valid;
    logic [DW-1:0] rdata_q;

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        fft_start = 1'b0;
        h_ack     = 1'b0;
        go_acc    = 1'b0;
        wd_expire = 1'b0;
        case (state)
            IDLE: begin
                busy  = 1'b0;
                h_ack = h_req;
                if (go) begin
                    go_acc    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                fft_start = 1'b1;
                state_nxt = ARM;
            end
            ARM: begin
                if (!fft_ready) begin
                    state_nxt = RUN;
                end else if (wd_cnt == WDW'(WD_LIM - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (fft_ready) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
            run_cycles  <= '0;
            h_rvalid    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state    <= state_nxt;
            h_rvalid <= h_ack && !h_we;
            if (h_rvalid) rdata_q <= m_rdata;

            if (state == LAUNCH)   wd_cnt <= '0;
            else if (state == ARM) wd_cnt <= wd_cnt + WDW'(1);

            if (go_acc)         err <= 1'b0;
            else if (wd_expire) err <= 1'b1;

            if (go_acc || (h_ack && h_we)) frame_valid <= 1'b0;
            else if (state == DONE)        frame_valid <= 1'b1;

            // The ARM cycle that sees ready fall is the engine's first busy cycle, so it counts too.
            if (go_acc) begin
                run_cycles <= '0;
            end else if ((state == ARM || state == RUN) && !fft_ready && run_cycles != 16'hFFFF) begin
                run_cycles <= run_cycles + 16'd1;
            end
        end
    end

    assign h_rdata   = h_rvalid ? m_rdata : rdata_q;
    assign fft_rdata = busy ? m_rdata : '0;

    fft_mem_mux #(.AW(AW), .DW(DW)) u_mux (
        .host_sel  (state == IDLE),
        .rev_en    (frame_valid),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .fft_cs    (fft_cs),
        .fft_we    (fft_we),
        .fft_addr  (fft_addr),
        .fft_wdata (fft_wdata),
        .m_cs      (m_cs),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata)
    );
endmodule
